// File: rtl/memory_access_unit.sv
// memory_access_unit
// Issues load/store/output requests from the memory functional unit onto a
// single-port request/grant data bus and a byte-stream transmitter port.
// Load results return in order on the CDB. A credit scheme bounds in-flight
// loads plus buffered responses so the response FIFO cannot overflow.
// Optional feature macro: MAU_PERF_COUNTERS_EN (adds perf_loads,
// perf_stores and perf_tx_stall outputs).
module memory_access_unit #(
    parameter int DATA_W     = 32,
    parameter int RSV_ID_W   = 8,
    parameter int INSTR_W    = 6,
    parameter int RESP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       i_valid,
    input  logic [INSTR_W-1:0]         i_opcode,
    input  logic [RSV_ID_W-1:0]        i_rsv_id,
    input  logic [DATA_W-1:0]          i_address,
    input  logic [DATA_W-1:0]          i_data,
    output logic                       i_ready,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [DATA_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_gnt,
    input  logic                       mem_rvalid,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic [RSV_ID_W+DATA_W-1:0] o_cdb,
    output logic                       o_cdb_valid,
    input  logic                       o_cdb_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready
`ifdef MAU_PERF_COUNTERS_EN
    ,
    output logic [31:0]                perf_loads,
    output logic [31:0]                perf_stores,
    output logic [31:0]                perf_tx_stall
`endif
);

    // Opcode encodings shared with the upstream functional unit
    localparam logic [INSTR_W-1:0] I_LOAD   = INSTR_W'(16);
    localparam logic [INSTR_W-1:0] I_LOADB  = INSTR_W'(17);
    localparam logic [INSTR_W-1:0] I_STORE  = INSTR_W'(18);
    localparam logic [INSTR_W-1:0] I_STOREB = INSTR_W'(19);
    localparam logic [INSTR_W-1:0] I_STORER = INSTR_W'(20);
    localparam logic [INSTR_W-1:0] I_OUTPUT = INSTR_W'(21);

    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = RSV_ID_W + DATA_W;

    typedef enum logic [1:0] {IDLE, REQ, TX} state_t;

    state_t              state, state_next;

    logic                is_load_op, is_store_op, is_out_op;
    logic                lat_load, lat_we;
    logic [DATA_W-1:0]   lat_addr, lat_wdata;
    logic [RSV_ID_W-1:0] lat_tag;
    logic [7:0]          lat_byte;

    logic [RSV_ID_W-1:0] tag_mem [RESP_DEPTH];
    logic [PW-1:0]       tag_wr, tag_rd;
    logic [EW-1:0]       rsp_mem [RESP_DEPTH];
    logic [PW-1:0]       rsp_wr, rsp_rd;
    logic [CW-1:0]       rsp_count, inflight, inflight_next, squash;

    logic                credits_full, accept, gnt_load;
    logic                rsp_push, rsp_pop, discard;

    assign is_load_op  = (i_opcode == I_LOAD) || (i_opcode == I_LOADB);
    assign is_store_op = (i_opcode == I_STORE) || (i_opcode == I_STOREB) ||
                         (i_opcode == I_STORER);
    assign is_out_op   = (i_opcode == I_OUTPUT);

    assign credits_full  = ({1'b0, inflight} + {1'b0, rsp_count}) >= (CW+1)'(RESP_DEPTH);
    assign accept        = i_valid && i_ready;
    assign gnt_load      = (state == REQ) && mem_gnt && lat_load;
    assign discard       = mem_rvalid && (squash != '0);
    assign rsp_push      = mem_rvalid && (squash == '0) && !clear;
    assign rsp_pop       = (rsp_count != '0) && o_cdb_ready && !clear;
    assign inflight_next = inflight + CW'(gnt_load) - CW'(mem_rvalid);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; unrecognised opcodes are accepted and dropped in IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_out_op)                      state_next = TX;
                    else if (is_load_op || is_store_op) state_next = REQ;
                end
            end
            REQ: begin
                // a granted load is already in flight and survives clear
                if (mem_gnt)                state_next = IDLE;
                else if (clear && lat_load) state_next = IDLE;
            end
            TX: begin
                if (tx_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode from state and response FIFO head
    always_comb begin
        i_ready     = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        tx_valid    = 1'b0;
        tx_data     = '0;
        o_cdb_valid = (rsp_count != '0);
        o_cdb       = o_cdb_valid ? rsp_mem[rsp_rd] : '0;
        case (state)
            IDLE: i_ready = !rst && !(is_load_op && credits_full);
            REQ: begin
                mem_req   = 1'b1;
                mem_we    = lat_we;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
            end
            TX: begin
                tx_valid = 1'b1;
                tx_data  = lat_byte;
            end
            default: ;
        endcase
    end

    // Request latch, captured on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_load  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_tag   <= '0;
            lat_byte  <= '0;
        end else if (accept) begin
            lat_load  <= is_load_op;
            lat_we    <= is_store_op;
            lat_addr  <= i_address;
            lat_wdata <= i_data;
            lat_tag   <= i_rsv_id;
            lat_byte  <= i_data[7:0];
        end
    end

    // Tag FIFO pointers: push on load grant, pop on every read beat
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wr <= '0;
            tag_rd <= '0;
        end else begin
            if (gnt_load)   tag_wr <= tag_wr + PW'(1);
            if (mem_rvalid) tag_rd <= tag_rd + PW'(1);
        end
    end

    // Tag and response FIFO storage
    always_ff @(posedge clk) begin
        if (gnt_load) tag_mem[tag_wr] <= lat_tag;
        if (rsp_push) rsp_mem[rsp_wr] <= {tag_mem[tag_rd], mem_rdata};
    end

    // Response FIFO pointers and occupancy; clear empties it
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rsp_wr    <= '0;
            rsp_rd    <= '0;
            rsp_count <= '0;
        end else begin
            if (rsp_push) rsp_wr <= rsp_wr + PW'(1);
            if (rsp_pop)  rsp_rd <= rsp_rd + PW'(1);
            rsp_count <= rsp_count + CW'(rsp_push) - CW'(rsp_pop);
        end
    end

    // In-flight load count and squash budget for beats owed to flushed loads
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
            squash   <= '0;
        end else begin
            inflight <= inflight_next;
            // inflight_next already counts a same-cycle grant and retires a same-cycle beat
            if (clear)        squash <= inflight_next;
            else if (discard) squash <= squash - CW'(1);
        end
    end

`ifdef MAU_PERF_COUNTERS_EN
    // Performance counters, cleared by rst only
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_loads    <= '0;
            perf_stores   <= '0;
            perf_tx_stall <= '0;
        end else begin
            if (gnt_load)                                 perf_loads    <= perf_loads + 32'd1;
            if ((state == REQ) && mem_gnt && !lat_load)   perf_stores   <= perf_stores + 32'd1;
            if ((state == TX) && !tx_ready)               perf_tx_stall <= perf_tx_stall + 32'd1;
        end
    end
`endif

endmodule
